bitwise_logic_acc: RTL and testbench

Parametrised, handshaked bitwise logic unit that supersedes the single-gate primitive. Each request computes AND, OR, XOR or NOR over WIDTH-bit operands. In single mode it emits one result per request. In accumulate mode it folds a packet of words into one result, which makes it usable for mask and flag reduction beside the ALU. Results pass through a one-entry registered output buffer with valid/ready flow control.

---
 rtl/bitwise_logic_acc.sv | 128 ++++++++++++
 tb/tb_bitwise_logic_acc.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_acc.sv
// Handshaked bitwise logic unit (AND/OR/XOR/NOR) with single-shot and packet-fold modes.
// Results are held in a one-entry registered output buffer with valid/ready flow control.
module bitwise_logic_acc #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_mode,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_y,
   output logic             out_zero,
   output logic [CNT_W-1:0] out_count
);

   typedef enum logic {StIdle, StAccum} state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_y_q, out_y_d;
   logic             out_zero_q, out_zero_d;
   logic [CNT_W-1:0] out_count_q, out_count_d;

   logic             accept;
   logic             load;
   logic [1:0]       op_eff;
   logic [WIDTH-1:0] lhs;
   logic [WIDTH-1:0] f_res;
   logic [CNT_W-1:0] cnt_next;

   function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
      logic [WIDTH-1:0] r;
      case (op)
         2'd0:    r = x & y;
         2'd1:    r = x | y;
         2'd2:    r = x ^ y;
         default: r = ~(x | y);
      endcase
      return r;
   endfunction

   // Buffer frees up in the same cycle it is drained, giving full throughput.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // First beat of a packet uses the live op and in_a; later beats fold into acc.
   assign op_eff   = (state_q == StIdle) ? in_op : op_q;
   assign lhs      = (state_q == StIdle) ? in_a : acc_q;
   assign f_res    = apply_op(op_eff, lhs, in_b);
   assign cnt_next = (state_q == StIdle) ? CNT_W'(1) :
                     (&cnt_q)            ? cnt_q : cnt_q + CNT_W'(1);
   assign load     = accept && ((state_q == StIdle) ? (!in_mode || in_last) : in_last);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_zero_d  = out_zero_q;
      out_count_d = out_count_q;

      if (accept) begin
         if (state_q == StIdle) begin
            op_d = in_op;
            if (in_mode && !in_last) begin
               state_d = StAccum;
               acc_d   = f_res;
               cnt_d   = cnt_next;
            end
         end else begin
            acc_d = f_res;
            cnt_d = cnt_next;
            if (in_last) state_d = StIdle;
         end
      end

      if (load) begin
         out_valid_d = 1'b1;
         out_y_d     = f_res;
         out_zero_d  = (f_res == '0);
         out_count_d = cnt_next;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= 2'd0;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_zero_q  <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_zero_q  <= out_zero_d;
         out_count_q <= out_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_zero  = out_zero_q;
   assign out_count = out_count_q;

endmodule

// File: tb/tb_bitwise_logic_acc.sv
// Scoreboard bench for bitwise_logic_acc: directed beats push expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_bitwise_logic_acc;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 8;

   typedef struct packed {
      logic [WIDTH-1:0] y;
      logic             zero;
      logic [CNT_W-1:0] count;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_op;
   logic             in_mode;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_zero;
   logic [CNT_W-1:0] out_count;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   bitwise_logic_acc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .in_mode   (in_mode),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_zero  (out_zero),
      .out_count (out_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_result(input logic [WIDTH-1:0] y, input logic [CNT_W-1:0] cnt);
      exp_t e;
      e.y     = y;
      e.zero  = (y == '0);
      e.count = cnt;
      exp_q.push_back(e);
   endtask

   // Called #1 after a posedge; returns #1 after the edge that accepts the beat.
   task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [1:0] op, input logic mode, input logic last);
      int n;
      in_a = a; in_b = b; in_op = op; in_mode = mode; in_last = last;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("beat_accept_timeout", 32'(in_ready), 32'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: one comparison per output transfer.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 32'(out_y), 32'hDEAD);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_y", 32'(out_y), 32'(e.y));
            check("out_zero", 32'(out_zero), 32'(e.zero));
            check("out_count", 32'(out_count), 32'(e.count));
         end
      end
   end

   initial begin
      int n;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'd0;
      in_mode = 1'b0; in_last = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_y", 32'(out_y), 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single AND, one-cycle latency
      expect_result(8'h30, 8'd1);
      beat(8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0);
      check("single_latency_valid", 32'(out_valid), 32'd1);

      // Accumulate XOR over three beats
      beat(8'h0F, 8'hFF, 2'd2, 1'b1, 1'b0);
      check("acc_xor_b1_no_valid", 32'(out_valid), 32'd0);
      beat(8'hAA, 8'h0F, 2'd0, 1'b0, 1'b0);
      check("acc_xor_b2_no_valid", 32'(out_valid), 32'd0);
      expect_result(8'h00, 8'd3);
      beat(8'h55, 8'hFF, 2'd1, 1'b1, 1'b1);
      check("acc_xor_done_valid", 32'(out_valid), 32'd1);

      // Back-to-back singles: NOR then OR
      expect_result(8'hFF, 8'd1);
      beat(8'h00, 8'h00, 2'd3, 1'b0, 1'b0);
      expect_result(8'h81, 8'd1);
      beat(8'h80, 8'h01, 2'd1, 1'b0, 1'b0);
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_y", 32'(out_y), 32'h81);

      // NOR fold without implicit inversion: ~(~(0F|F0)|01) = FE
      beat(8'h0F, 8'hF0, 2'd3, 1'b1, 1'b0);
      expect_result(8'hFE, 8'd2);
      beat(8'h00, 8'h01, 2'd0, 1'b1, 1'b1);

      // Backpressure with a pending beat
      @(posedge clk); #1;
      out_ready = 1'b0;
      expect_result(8'h30, 8'd1);
      beat(8'hF0, 8'h3C, 2'd0, 1'b0, 1'b0);
      expect_result(8'h03, 8'd1);
      in_a = 8'h01; in_b = 8'h02; in_op = 2'd1; in_mode = 1'b0; in_last = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_y_stable", 32'(out_y), 32'h30);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("bp_new_valid", 32'(out_valid), 32'd1);
      check("bp_new_y", 32'(out_y), 32'h03);

      // Reset mid-packet discards the open OR packet
      beat(8'h01, 8'h02, 2'd1, 1'b1, 1'b0);
      beat(8'h00, 8'h04, 2'd1, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      expect_result(8'h03, 8'd1);
      beat(8'h01, 8'h02, 2'd1, 1'b0, 1'b0);

      // Op/mode latched on the first beat
      beat(8'h01, 8'h02, 2'd1, 1'b1, 1'b0);
      expect_result(8'h07, 8'd2);
      beat(8'hFF, 8'h04, 2'd0, 1'b0, 1'b1);

      // Count saturation over 300 beats
      for (int i = 0; i < 299; i++) begin
         beat(8'h00, 8'h00, 2'd1, 1'b1, 1'b0);
      end
      expect_result(8'h00, 8'd255);
      beat(8'h00, 8'h00, 2'd1, 1'b1, 1'b1);

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      @(posedge clk); #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
